// File: rtl/max7219_display_ctrl.sv
// rtl/max7219_display_ctrl.sv - MAX7219 power-up/init/digit command sequencer for a serializer
// Optional build macro: MAX7219_LEADING_ZERO_BLANK_EN (blank leading zero digits 8..2)
`timescale 1ns/1ps
module max7219_display_ctrl #(
    parameter int POWERUP_CYCLES = 12000,
    parameter int REFRESH_CYCLES = 12000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits_in,
    input  logic        update,
    input  logic [3:0]  intensity,
    output logic [7:0]  drv_addr,
    output logic [7:0]  drv_data,
    output logic        drv_start,
    input  logic        drv_busy,
    output logic        ready,
    output logic        cmd_err
);
    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_ACK   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_IDLE  = 3'd4;

    // Command index space: 0..4 init registers, 5..12 digit registers 1..8
    localparam logic [3:0] IDX_INT  = 4'd4;
    localparam logic [3:0] IDX_DIG  = 4'd5;
    localparam logic [3:0] IDX_LAST = 4'd12;

    localparam int PW_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;

    logic [2:0]      state;
    logic [3:0]      idx;
    logic            single;
    logic [PW_W-1:0] pw_cnt;
    logic [1:0]      ack_cnt;
    logic [31:0]     digits;
    logic [31:0]     pend_digits;
    logic            pend_flag;
    logic            refresh_flag;
    logic            refresh_tick;
    logic [3:0]      sent_int;
    logic [31:0]     next_pend;
    logic [7:0]      cmd_addr;
    logic [7:0]      cmd_data;
    logic [2:0]      dig_k;
    logic [3:0]      nib;

    function automatic logic [7:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 8'h7E;  4'h1: seg7 = 8'h30;  4'h2: seg7 = 8'h6D;  4'h3: seg7 = 8'h79;
            4'h4: seg7 = 8'h33;  4'h5: seg7 = 8'h5B;  4'h6: seg7 = 8'h5F;  4'h7: seg7 = 8'h70;
            4'h8: seg7 = 8'h7F;  4'h9: seg7 = 8'h7B;  4'hA: seg7 = 8'h77;  4'hB: seg7 = 8'h1F;
            4'hC: seg7 = 8'h4E;  4'hD: seg7 = 8'h3D;  4'hE: seg7 = 8'h4F;  default: seg7 = 8'h47;
        endcase
    endfunction

    generate
        if (REFRESH_CYCLES > 0) begin : g_refresh
            localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
            logic [RW-1:0] rcnt;
            always_ff @(posedge clk) begin
                if (rst || rcnt == RW'(REFRESH_CYCLES - 1)) rcnt <= '0;
                else                                       rcnt <= rcnt + 1'b1;
            end
            assign refresh_tick = (rcnt == RW'(REFRESH_CYCLES - 1));
        end else begin : g_no_refresh
            assign refresh_tick = 1'b0;
        end
    endgenerate

    // An update pulse in the same cycle as a list start wins over the older pending value
    assign next_pend = update ? digits_in : pend_digits;
    assign ready     = (state == S_IDLE);
    assign dig_k     = 3'(idx - IDX_DIG);
    assign nib       = digits[{dig_k, 2'b00} +: 4];

    always_comb begin
        cmd_addr = 8'h00;
        cmd_data = 8'h00;
        case (idx)
            4'd0:    begin cmd_addr = 8'h0C; cmd_data = 8'h01; end
            4'd1:    begin cmd_addr = 8'h0F; cmd_data = 8'h00; end
            4'd2:    begin cmd_addr = 8'h09; cmd_data = 8'h00; end
            4'd3:    begin cmd_addr = 8'h0B; cmd_data = 8'h07; end
            4'd4:    begin cmd_addr = 8'h0A; cmd_data = {4'h0, intensity}; end
            default: begin
                cmd_addr = {5'd0, dig_k} + 8'd1;
`ifdef MAX7219_LEADING_ZERO_BLANK_EN
                if (dig_k != 3'd0 && (digits >> {dig_k, 2'b00}) == 32'd0) cmd_data = 8'h00;
                else                                                      cmd_data = seg7(nib);
`else
                cmd_data = seg7(nib);
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_PWRUP;
            idx          <= 4'd0;
            single       <= 1'b0;
            pw_cnt       <= '0;
            ack_cnt      <= 2'd0;
            digits       <= 32'd0;
            pend_digits  <= 32'd0;
            pend_flag    <= 1'b0;
            refresh_flag <= 1'b0;
            sent_int     <= 4'h0;
            drv_addr     <= 8'h00;
            drv_data     <= 8'h00;
            drv_start    <= 1'b0;
            cmd_err      <= 1'b0;
        end else begin
            drv_start <= 1'b0;
            if (refresh_tick) refresh_flag <= 1'b1;
            if (update) begin
                pend_digits <= digits_in;
                pend_flag   <= 1'b1;
            end
            case (state)
                S_PWRUP: begin
                    if (pw_cnt == PW_W'(POWERUP_CYCLES - 1)) begin
                        idx          <= 4'd0;
                        single       <= 1'b0;
                        digits       <= next_pend;
                        pend_flag    <= 1'b0;
                        refresh_flag <= refresh_tick;
                        state        <= S_ISSUE;
                    end else begin
                        pw_cnt <= pw_cnt + 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!drv_busy) begin
                        drv_addr  <= cmd_addr;
                        drv_data  <= cmd_data;
                        drv_start <= 1'b1;
                        ack_cnt   <= 2'd0;
                        if (idx == IDX_INT) sent_int <= intensity;
                        state     <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (drv_busy) begin
                        state <= S_DONE;
                    end else if (ack_cnt == 2'd3) begin
                        cmd_err <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 2'd1;
                    end
                end
                S_DONE: begin
                    if (!drv_busy) begin
                        if (single || idx == IDX_LAST) begin
                            state <= S_IDLE;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_IDLE: begin
                    if (refresh_flag) begin
                        idx          <= 4'd0;
                        single       <= 1'b0;
                        digits       <= next_pend;
                        pend_flag    <= 1'b0;
                        refresh_flag <= refresh_tick;
                        state        <= S_ISSUE;
                    end else if (intensity != sent_int) begin
                        idx    <= IDX_INT;
                        single <= 1'b1;
                        state  <= S_ISSUE;
                    end else if (update || pend_flag) begin
                        idx       <= IDX_DIG;
                        single    <= 1'b0;
                        digits    <= next_pend;
                        pend_flag <= 1'b0;
                        state     <= S_ISSUE;
                    end
                end
                default: state <= S_PWRUP;
            endcase
        end
    end
endmodule
